// File: rtl/picorv_native_mem.sv
// picorv_native_mem: responder for the picorv32 native memory interface.
//
// Serves a word-addressed on-chip RAM plus an MMIO UART transmitter so the core
// can run without the cache path.
//
// Address map:
//   [0, MemBytes)  RAM (byte-lane writes, synchronous read)
//   0x2000_0000    TXDATA, write only; wstrb[0]=1 pushes wdata[7:0] into the TX FIFO
//   0x2000_0004    STATUS, read only: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy,
//                  [15:8] fifo_level
//   0x2000_0008    cycle counter, only when PICORV_NATIVE_CYCLE_CNT_EN is defined
//   anything else  unmapped: reads 0, writes have no effect
//
// Optional feature macro: PICORV_NATIVE_CYCLE_CNT_EN
//   When it is defined, a free-running 32-bit cycle counter is readable at
//   0x2000_0008. The value returned is the count in the ACCESS cycle.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous, active-high reset
//   mem_valid_i  request valid, held by the core until mem_ready_o
//   mem_addr_i   byte address, word aligned
//   mem_wdata_i  write data
//   mem_wstrb_i  byte enables, 0 = read
//   mem_ready_o  one-cycle completion pulse
//   mem_rdata_o  read data, valid with mem_ready_o; holds otherwise
//   tx_o         UART 8N1 serial output, idle high
//
// Handshake: IDLE -> ACCESS -> RESP -> IDLE. A request sampled in cycle N completes
// in cycle N+2. The exception is a TXDATA push into a full FIFO, which stalls in ACCESS.
module picorv_native_mem #(
  parameter int unsigned ClkFreq     = 12000000,
  parameter int unsigned BaudRate    = 115200,
  parameter int unsigned MemBytes    = 32'h20000,
  parameter int unsigned TxFifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        tx_o
);

  localparam int unsigned RamWords  = MemBytes / 4;
  localparam int unsigned RamAw     = $clog2(RamWords);
  localparam int unsigned PtrW      = $clog2(TxFifoDepth);
  localparam int unsigned LevelW    = PtrW + 1;
  localparam int unsigned BitCycles = ClkFreq / BaudRate;
  localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;

  localparam logic [31:0] AddrTxData = 32'h2000_0000;
  localparam logic [31:0] AddrStatus = 32'h2000_0004;
`ifdef PICORV_NATIVE_CYCLE_CNT_EN
  localparam logic [31:0] AddrCycle  = 32'h2000_0008;
`endif
  localparam logic [31:0] RamLimit   = 32'(MemBytes);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Bus-side state
  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  // Set for the single IDLE cycle after RESP, in which valid is still being dropped
  logic        skip_q;

  // Storage
  logic [31:0] ram [0:RamWords-1];
  logic [7:0]  fifo_mem [0:TxFifoDepth-1];

  // TX FIFO state
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [LevelW-1:0] level_q;

  // Serializer state
  logic            busy_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [3:0]      bit_idx_q;
  logic [8:0]      shift_q;

`ifdef PICORV_NATIVE_CYCLE_CNT_EN
  logic [31:0] cycle_q;
`endif

  // Decode and datapath
  logic            is_ram;
  logic            is_tx;
  logic            is_stat;
`ifdef PICORV_NATIVE_CYCLE_CNT_EN
  logic            is_cyc;
`endif
  logic            is_read;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            stall;
  logic            frame_end;
  logic [RamAw-1:0] ram_idx;
  logic [31:0]     status_word;
  logic [31:0]     access_rdata;

  always_comb begin
    is_ram   = addr_q < RamLimit;
    is_tx    = addr_q == AddrTxData;
    is_stat  = addr_q == AddrStatus;
`ifdef PICORV_NATIVE_CYCLE_CNT_EN
    is_cyc   = addr_q == AddrCycle;
`endif
    is_read  = wstrb_q == 4'b0000;
    ram_idx  = addr_q[RamAw+1:2];

    fifo_full  = level_q == LevelW'(TxFifoDepth);
    fifo_empty = level_q == '0;

    // A push into a full FIFO waits; a slot freed by a pop is usable the next cycle
    push  = (state_q == StAccess) && is_tx && wstrb_q[0] && !fifo_full;
    stall = (state_q == StAccess) && is_tx && wstrb_q[0] && fifo_full;

    // Last cycle of the stop bit: the next byte is popped here so frames abut
    frame_end = busy_q && (bit_idx_q == 4'd9) && (baud_cnt_q == CntW'(BitCycles - 1));
    pop       = !fifo_empty && (!busy_q || frame_end);

    // fifo_level is zero-extended into an 8-bit field
    status_word = {16'h0000, 8'(level_q), 5'b00000, busy_q, fifo_empty, fifo_full};

    access_rdata = 32'h0000_0000;
    if (is_ram) begin
      access_rdata = ram[ram_idx];
    end else if (is_stat) begin
      access_rdata = status_word;
`ifdef PICORV_NATIVE_CYCLE_CNT_EN
    end else if (is_cyc) begin
      access_rdata = cycle_q;
`endif
    end
  end

  // Bus FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      skip_q      <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= 32'h0;
    end else begin
      mem_ready_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (mem_valid_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!stall) begin
            state_q     <= StResp;
            mem_ready_o <= 1'b1;
            if (is_read) begin
              mem_rdata_o <= access_rdata;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          skip_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM write port; contents are not reset
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == StAccess) && is_ram && !is_read) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          ram[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // FIFO storage; contents are not reset, only the pointers are
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      fifo_mem[wr_ptr_q] <= wdata_q[7:0];
    end
  end

  // FIFO pointers and level; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q <= level_q + LevelW'(push) - LevelW'(pop);
    end
  end

  // 8N1 serializer. shift_q holds {stop, data}; the start bit is driven on pop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q     <= 1'b0;
      tx_o       <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 9'h1ff;
    end else if (pop) begin
      busy_q     <= 1'b1;
      tx_o       <= 1'b0;
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= {1'b1, fifo_mem[rd_ptr_q]};
    end else if (busy_q) begin
      if (baud_cnt_q == CntW'(BitCycles - 1)) begin
        baud_cnt_q <= '0;
        if (bit_idx_q == 4'd9) begin
          busy_q <= 1'b0;
          tx_o   <= 1'b1;
        end else begin
          tx_o      <= shift_q[0];
          shift_q   <= {1'b1, shift_q[8:1]};
          bit_idx_q <= bit_idx_q + 4'd1;
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + CntW'(1);
      end
    end
  end

`ifdef PICORV_NATIVE_CYCLE_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
`endif

endmodule
